// File: rtl/tournament_predictor_pkg.sv
// Shared defaults, counter types and saturating-counter helpers for the
// tournament direction predictor.
package tournament_predictor_pkg;

  localparam int PHT_ENTRIES_DEF  = 256;
  localparam int HISTORY_BITS_DEF = 8;
  localparam int CTR_BITS_DEF     = 2;
  localparam int CTR_MAX_BITS     = 8;

  typedef logic [CTR_BITS_DEF-1:0] ctr_t;
  typedef logic [CTR_MAX_BITS-1:0] ctr_wide_t;

  typedef enum logic {
    SEL_BIMODAL = 1'b0,
    SEL_GSHARE  = 1'b1
  } chooser_sel_e;

  // Helpers work on a wide container so any counter width up to 8 bits fits.
  function automatic ctr_wide_t sat_inc(input ctr_wide_t v, input int unsigned bits);
    ctr_wide_t max_v;
    max_v = ctr_wide_t'((32'd1 << bits) - 32'd1);
    return (v >= max_v) ? v : v + ctr_wide_t'(1);
  endfunction

  function automatic ctr_wide_t sat_dec(input ctr_wide_t v);
    return (v == '0) ? v : v - ctr_wide_t'(1);
  endfunction

endpackage

// File: rtl/tournament_predictor_if.sv
// Fetch-lookup, execute-training and recovery signals of the predictor.
interface tournament_predictor_if
  import tournament_predictor_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int EX_WIDTH     = 2,
  parameter int HISTORY_BITS = HISTORY_BITS_DEF
);
  logic [FETCH_WIDTH-1:0][31:0]           if_pc_i;
  logic [FETCH_WIDTH-1:0]                 if_cond_i;
  logic                                   fetch_fire_i;
  logic [FETCH_WIDTH-1:0]                 pred_taken_o;
  logic [FETCH_WIDTH-1:0]                 gshare_pred_o;
  logic [FETCH_WIDTH-1:0]                 bimodal_pred_o;
  logic [FETCH_WIDTH-1:0][HISTORY_BITS-1:0] history_o;
  logic [EX_WIDTH-1:0]                    ex_valid_i;
  logic [EX_WIDTH-1:0][31:0]              ex_pc_i;
  logic [EX_WIDTH-1:0]                    ex_taken_i;
  logic [EX_WIDTH-1:0][HISTORY_BITS-1:0]  ex_history_i;
  logic [EX_WIDTH-1:0]                    ex_gshare_pred_i;
  logic [EX_WIDTH-1:0]                    ex_bimodal_pred_i;
  logic                                   recover_i;
  logic [HISTORY_BITS-1:0]                recover_history_i;
  logic                                   recover_taken_i;
  logic [HISTORY_BITS-1:0]                ghr_o;

  modport master (
    output if_pc_i, if_cond_i, fetch_fire_i,
    output ex_valid_i, ex_pc_i, ex_taken_i, ex_history_i, ex_gshare_pred_i, ex_bimodal_pred_i,
    output recover_i, recover_history_i, recover_taken_i,
    input  pred_taken_o, gshare_pred_o, bimodal_pred_o, history_o, ghr_o
  );

  modport slave (
    input  if_pc_i, if_cond_i, fetch_fire_i,
    input  ex_valid_i, ex_pc_i, ex_taken_i, ex_history_i, ex_gshare_pred_i, ex_bimodal_pred_i,
    input  recover_i, recover_history_i, recover_taken_i,
    output pred_taken_o, gshare_pred_o, bimodal_pred_o, history_o, ghr_o
  );
endinterface

// File: rtl/tournament_predictor_sat_counter_table.sv
// Flop array of saturating counters with ordered inc/dec write ports.
// Contents are exported whole so callers can index them combinationally.
module tournament_predictor_sat_counter_table
  import tournament_predictor_pkg::*;
#(
  parameter int                  ENTRIES   = PHT_ENTRIES_DEF,
  parameter int                  CTR_BITS  = CTR_BITS_DEF,
  parameter int                  WR_PORTS  = 2,
  parameter logic [CTR_BITS-1:0] RESET_VAL = '0,
  localparam int                 IDX       = $clog2(ENTRIES)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [WR_PORTS-1:0]                 wr_en_i,
  input  logic [WR_PORTS-1:0][IDX-1:0]        wr_idx_i,
  input  logic [WR_PORTS-1:0]                 wr_inc_i,
  output logic [ENTRIES-1:0][CTR_BITS-1:0]    state_o
);

  logic [ENTRIES-1:0][CTR_BITS-1:0] mem_q, mem_d;

  always_comb begin
    // NOTE: mem_d starts as a full copy of mem_q so every path assigns it and no latch is inferred.
    mem_d = mem_q;
    // NOTE: blocking '=' is deliberate: port k reads port k-1's result, so same-entry updates accumulate.
    for (int k = 0; k < WR_PORTS; k++) begin
      if (wr_en_i[k]) begin
        mem_d[wr_idx_i[k]] = wr_inc_i[k]
          ? CTR_BITS'(sat_inc(ctr_wide_t'(mem_d[wr_idx_i[k]]), CTR_BITS))
          : CTR_BITS'(sat_dec(ctr_wide_t'(mem_d[wr_idx_i[k]])));
      end
    end
  end

  // NOTE: the table is plain flops, so every entry can be cleared by reset; an SRAM macro could not be.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mem_q <= {ENTRIES{RESET_VAL}};
    else       mem_q <= mem_d;
  end

  assign state_o = mem_q;

endmodule

// File: rtl/tournament_predictor.sv
// Tournament (gshare + bimodal + chooser) conditional-branch direction predictor
// with a speculative global history register and per-lane history chaining.
module tournament_predictor
  import tournament_predictor_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int EX_WIDTH     = 2,
  parameter int PHT_ENTRIES  = PHT_ENTRIES_DEF,
  parameter int HISTORY_BITS = HISTORY_BITS_DEF,
  parameter int CTR_BITS     = CTR_BITS_DEF
) (
  input logic                  clock,
  input logic                  reset,
  tournament_predictor_if.slave bus
);

  localparam int                  IDX      = $clog2(PHT_ENTRIES);
  localparam int                  HB       = HISTORY_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef logic [IDX-1:0] idx_t;
  typedef logic [HB-1:0]  hist_t;

  logic [EX_WIDTH-1:0]               cho_wr_en, cho_wr_inc;
  logic [EX_WIDTH-1:0][IDX-1:0]      pc_wr_idx, gsh_wr_idx;
  logic [PHT_ENTRIES-1:0][CTR_BITS-1:0] gsh_state, bim_state, cho_state;
  hist_t                             ghr_q, ghr_d;
  logic                              unused_bits;

  always_comb begin
    pc_wr_idx  = '0;
    gsh_wr_idx = '0;
    cho_wr_en  = '0;
    cho_wr_inc = '0;
    for (int k = 0; k < EX_WIDTH; k++) begin
      pc_wr_idx[k]  = bus.ex_pc_i[k][IDX+1:2];
      gsh_wr_idx[k] = pc_wr_idx[k] ^ idx_t'(bus.ex_history_i[k]);
      // The chooser only learns when the two components disagreed.
      cho_wr_en[k]  = bus.ex_valid_i[k] & (bus.ex_gshare_pred_i[k] != bus.ex_bimodal_pred_i[k]);
      cho_wr_inc[k] = (bus.ex_gshare_pred_i[k] == bus.ex_taken_i[k]);
    end
  end

  tournament_predictor_sat_counter_table #(
    .ENTRIES(PHT_ENTRIES), .CTR_BITS(CTR_BITS), .WR_PORTS(EX_WIDTH), .RESET_VAL(CTR_INIT)
  ) u_gshare (
    .clock(clock), .reset(reset), .wr_en_i(bus.ex_valid_i), .wr_idx_i(gsh_wr_idx),
    .wr_inc_i(bus.ex_taken_i), .state_o(gsh_state)
  );

  tournament_predictor_sat_counter_table #(
    .ENTRIES(PHT_ENTRIES), .CTR_BITS(CTR_BITS), .WR_PORTS(EX_WIDTH), .RESET_VAL(CTR_INIT)
  ) u_bimodal (
    .clock(clock), .reset(reset), .wr_en_i(bus.ex_valid_i), .wr_idx_i(pc_wr_idx),
    .wr_inc_i(bus.ex_taken_i), .state_o(bim_state)
  );

  tournament_predictor_sat_counter_table #(
    .ENTRIES(PHT_ENTRIES), .CTR_BITS(CTR_BITS), .WR_PORTS(EX_WIDTH), .RESET_VAL(CTR_INIT)
  ) u_chooser (
    .clock(clock), .reset(reset), .wr_en_i(cho_wr_en), .wr_idx_i(pc_wr_idx),
    .wr_inc_i(cho_wr_inc), .state_o(cho_state)
  );

  // Each lane owns its signals so the history chain is a clean ripple, not a loop on one vector.
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    hist_t        h_in, h_out;
    logic         taken_seen_in, taken_seen_out;
    idx_t         pc_idx, gsh_idx;
    logic         gsh_pred, bim_pred, final_pred;
    chooser_sel_e sel;

    if (i == 0) begin : g_head
      assign h_in          = ghr_q;
      assign taken_seen_in = 1'b0;
    end else begin : g_chain
      assign h_in          = g_lane[i-1].h_out;
      assign taken_seen_in = g_lane[i-1].taken_seen_out;
    end

    assign pc_idx         = bus.if_pc_i[i][IDX+1:2];
    assign gsh_idx        = pc_idx ^ idx_t'(h_in);
    assign gsh_pred       = gsh_state[gsh_idx][CTR_BITS-1];
    assign bim_pred       = bim_state[pc_idx][CTR_BITS-1];
    assign sel            = chooser_sel_e'(cho_state[pc_idx][CTR_BITS-1]);
    assign final_pred     = bus.if_cond_i[i] & ((sel == SEL_GSHARE) ? gsh_pred : bim_pred);
    assign h_out          = (bus.if_cond_i[i] && !taken_seen_in) ? {h_in[HB-2:0], final_pred} : h_in;
    assign taken_seen_out = taken_seen_in | final_pred;

    assign bus.pred_taken_o[i]   = final_pred;
    assign bus.gshare_pred_o[i]  = gsh_pred;
    assign bus.bimodal_pred_o[i] = bim_pred;
    assign bus.history_o[i]      = h_in;
  end

  always_comb begin
    ghr_d = ghr_q;
    if (bus.recover_i)         ghr_d = {bus.recover_history_i[HB-2:0], bus.recover_taken_i};
    else if (bus.fetch_fire_i) ghr_d = g_lane[FETCH_WIDTH-1].h_out;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign bus.ghr_o = ghr_q;

  // PC bits outside the index and the oldest recovered history bit never matter.
  always_comb begin
    unused_bits = bus.recover_history_i[HB-1];
    for (int i = 0; i < FETCH_WIDTH; i++)
      unused_bits ^= ^{bus.if_pc_i[i][31:IDX+2], bus.if_pc_i[i][1:0]};
    for (int k = 0; k < EX_WIDTH; k++)
      unused_bits ^= ^{bus.ex_pc_i[k][31:IDX+2], bus.ex_pc_i[k][1:0]};
  end

endmodule
